// File: rtl/uart_rx_deser.sv
// UART receiver: 2-flop synchronised rx_in, 8 data bits LSB first, one stop bit, sticky error flags.
// Define UART_RX_PARITY_EN to add an even-parity bit after bit 7 and the parity_err output.
module uart_rx_deser #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       Clk,
    input  logic       reset,
    input  logic       rx_in,
    input  logic       rx_ack,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_err,
    output logic       overrun_err,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       busy
);

    localparam int            CW      = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic          rx_meta_q, rx_sync_q, rx_prev_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [7:0]    data_q, data_d;
    logic          dv_q, dv_d;
    logic          fe_q, fe_d;
    logic          ov_q, ov_d;
    logic          good_stop;
`ifdef UART_RX_PARITY_EN
    logic          pe_q, pe_d;
    logic          pbad_q, pbad_d;
`endif

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shreg_q   <= '0;
            data_q    <= '0;
            dv_q      <= 1'b0;
            fe_q      <= 1'b0;
            ov_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            pe_q      <= 1'b0;
            pbad_q    <= 1'b0;
`endif
        end else begin
            rx_meta_q <= rx_in;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shreg_q   <= shreg_d;
            data_q    <= data_d;
            dv_q      <= dv_d;
            fe_q      <= fe_d;
            ov_q      <= ov_d;
`ifdef UART_RX_PARITY_EN
            pe_q      <= pe_d;
            pbad_q    <= pbad_d;
`endif
        end
    end

`ifdef UART_RX_PARITY_EN
    assign good_stop = rx_sync_q && !pbad_q;
`else
    assign good_stop = rx_sync_q;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        dv_d    = dv_q;
        fe_d    = fe_q;
        ov_d    = ov_q;
`ifdef UART_RX_PARITY_EN
        pe_d    = pe_q;
        pbad_d  = pbad_q;
`endif
        // Ack clears first; events in this same cycle then override it.
        if (rx_ack) begin
            dv_d = 1'b0;
            fe_d = 1'b0;
            ov_d = 1'b0;
`ifdef UART_RX_PARITY_EN
            pe_d = 1'b0;
`endif
        end

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                bit_d = '0;
`ifdef UART_RX_PARITY_EN
                pbad_d = 1'b0;
`endif
                // A falling edge needs rx_prev_q=1, so after a framing error the
                // line must be seen high before another start is accepted.
                if (rx_prev_q && !rx_sync_q) begin
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    state_d = rx_sync_q ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shreg_d = {rx_sync_q, shreg_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    state_d = STOP;
                    if ((^shreg_q) != rx_sync_q) begin
                        pbad_d = 1'b1;
                        pe_d   = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (!rx_sync_q) begin
                        fe_d = 1'b1;
                    end else if (good_stop) begin
                        if (!dv_q || rx_ack) begin
                            data_d = shreg_q;
                            dv_d   = 1'b1;
                        end else begin
                            ov_d = 1'b1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign data_out    = data_q;
    assign data_valid  = dv_q;
    assign frame_err   = fe_q;
    assign overrun_err = ov_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err  = pe_q;
`endif
    assign busy        = (state_q != IDLE);

endmodule
